// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;

    // Register index as seen by the hazard logic.
    typedef logic [REG_W_DEFAULT-1:0] regbits_t;

    // Controller state.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        LDSTALL = 2'd2,
        HALT    = 2'd3
    } hzstate_t;

endpackage

// File: rtl/hazard_stall_ctrl_load_use.sv
// Load-use hazard detect: a load in ID/EX whose destination feeds the IF/ID instruction.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             hazard_o
);

    // Register 0 is hardwired, so a load into it never creates a dependence.
    always_comb begin
        hazard_o = idex_memread_i
                 && (idex_rt_i != '0)
                 && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline controller: derives WEN/flush for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Priority each cycle: halt > dcache wait > redirect > load-use > ifetch.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ihit_i,
    input  logic             dhit_i,
    input  logic             exmem_memop_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             exmem_redirect_i,
    input  logic             memwb_halt_i,
    output logic             pc_wen_o,
    output logic             ifid_wen_o,
    output logic             ifid_flush_o,
    output logic             idex_wen_o,
    output logic             idex_flush_o,
    output logic             exmem_wen_o,
    output logic             exmem_flush_o,
    output logic             memwb_wen_o,
    output logic             memwb_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hzstate_t         state_q, state_d;
    logic             redirect_pend_q, redirect_pend_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic halt_now;
    logic dwait;
    logic back_adv;
    logic redirect_go;
    logic pend_go;
    logic ldstall_go;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .hazard_o       (load_use)
    );

    // Cycle classification shared by next-state and output decode.
    always_comb begin
        halt_now    = (state_q == HALT) || memwb_halt_i;
        dwait       = exmem_memop_i && !dhit_i;
        back_adv    = !halt_now && !dwait;
        redirect_go = back_adv && exmem_redirect_i;
        // A deferred IF/ID squash discards the IF/ID instruction, so it beats load-use.
        pend_go     = back_adv && !exmem_redirect_i && redirect_pend_q && ihit_i;
        ldstall_go  = back_adv && !exmem_redirect_i && !pend_go && load_use;
    end

    // State, pending-squash flag, halt flag and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
            halted_q        <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            halted_q        <= halted_q || memwb_halt_i;
            if (!pc_wen_o && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Next state and pending-squash bookkeeping.
    always_comb begin
        state_d         = RUN;
        redirect_pend_d = redirect_pend_q;
        if (halt_now) begin
            state_d = HALT;
        end else if (dwait) begin
            state_d = DWAIT;
        end else if (redirect_go) begin
            // IF/ID cannot be squashed without a fetch; remember to do it later.
            redirect_pend_d = !ihit_i;
        end else if (pend_go) begin
            redirect_pend_d = 1'b0;
        end else if (ldstall_go) begin
            state_d = LDSTALL;
        end
    end

    // Output decode; everything is forced idle while reset is asserted.
    always_comb begin
        pc_wen_o      = 1'b0;
        ifid_wen_o    = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_wen_o    = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_wen_o   = 1'b0;
        exmem_flush_o = 1'b0;
        memwb_wen_o   = 1'b0;
        memwb_flush_o = 1'b0;
        if (rst_n && back_adv) begin
            idex_wen_o  = 1'b1;
            exmem_wen_o = 1'b1;
            memwb_wen_o = 1'b1;
            if (redirect_go) begin
                pc_wen_o      = ihit_i;
                ifid_wen_o    = ihit_i;
                ifid_flush_o  = ihit_i;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
            end else if (pend_go) begin
                pc_wen_o     = 1'b1;
                ifid_wen_o   = 1'b1;
                ifid_flush_o = 1'b1;
            end else begin
                // Front end holds on a miss or a load-use hazard; ID/EX takes a bubble.
                pc_wen_o     = ihit_i && !ldstall_go;
                ifid_wen_o   = ihit_i && !ldstall_go;
                idex_flush_o = !(ihit_i && !ldstall_go);
            end
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench for hazard_stall_ctrl with a rule-level reference model.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ihit, dhit, exmem_memop, idex_memread, exmem_redirect, memwb_halt;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic        exmem_wen, exmem_flush, memwb_wen, memwb_flush, halted;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_halted;
    bit m_pend;
    int m_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ihit_i           (ihit),
        .dhit_i           (dhit),
        .exmem_memop_i    (exmem_memop),
        .idex_memread_i   (idex_memread),
        .idex_rt_i        (idex_rt),
        .ifid_rs_i        (ifid_rs),
        .ifid_rt_i        (ifid_rt),
        .exmem_redirect_i (exmem_redirect),
        .memwb_halt_i     (memwb_halt),
        .pc_wen_o         (pc_wen),
        .ifid_wen_o       (ifid_wen),
        .ifid_flush_o     (ifid_flush),
        .idex_wen_o       (idex_wen),
        .idex_flush_o     (idex_flush),
        .exmem_wen_o      (exmem_wen),
        .exmem_flush_o    (exmem_flush),
        .memwb_wen_o      (memwb_wen),
        .memwb_flush_o    (memwb_flush),
        .halted_o         (halted),
        .stall_cnt_o      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational and registered outputs, advance model.
    task automatic step(input bit rn, input bit ih, input bit dh, input bit mo, input bit mr,
                        input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                        input bit rd, input bit hl, input string tag);
        bit [8:0] exp;
        bit pc, fw, ff, xf, mf, nxt_pend, hz;
        rst_n = rn; ihit = ih; dhit = dh; exmem_memop = mo; idex_memread = mr;
        idex_rt = rt; ifid_rs = rs; ifid_rt = rt2; exmem_redirect = rd; memwb_halt = hl;
        if (!rn) begin
            m_halted = 0; m_pend = 0; m_cnt = 0;
        end
        #1;
        pc = 0; fw = 0; ff = 0; xf = 0; mf = 0; nxt_pend = m_pend;
        exp = '0;
        if (rn && !m_halted && !hl && !(mo && !dh)) begin
            // back end moves; decide the front end and what gets squashed
            hz = mr && (rt != 0) && (rt == rs || rt == rt2);
            if (rd) begin
                pc = ih; fw = ih; ff = ih; xf = 1; mf = 1; nxt_pend = !ih;
            end else if (m_pend && ih) begin
                pc = 1; fw = 1; ff = 1; nxt_pend = 0;
            end else begin
                pc = ih && !hz; fw = pc; xf = !pc;
            end
            exp = {pc, fw, ff, 1'b1, xf, 1'b1, mf, 1'b1, 1'b0};
        end
        chk({tag, ":ctl"}, {23'd0, pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
                            exmem_wen, exmem_flush, memwb_wen, memwb_flush}, {23'd0, exp});
        chk({tag, ":halted"}, {31'd0, halted}, {31'd0, m_halted});
        chk({tag, ":cnt"}, {16'd0, stall_cnt}, m_cnt);
        @(posedge clk);
        if (rn) begin
            if (!exp[8] && !m_halted && m_cnt < 65535) m_cnt++;
            m_pend = nxt_pend;
            if (hl) m_halted = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst_n = 0; ihit = 0; dhit = 0; exmem_memop = 0; idex_memread = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0; exmem_redirect = 0; memwb_halt = 0;
        m_halted = 0; m_pend = 0; m_cnt = 0;
        @(negedge clk);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
        idle("run");

        // load-use on $2, then the same with $0
        step(1, 1, 1, 0, 1, 5'd2, 5'd2, 5'd7, 0, 0, "lu");
        idle("lu_after");
        chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        step(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, "lu_r0");

        // dcache wait three cycles, ihit low, then dhit
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "dwait");
        step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, "dhit");
        idle("dw_after");
        chk("dw_cnt", {16'd0, stall_cnt}, 32'd5);

        // redirect with fetch miss, then deferred squash
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "redir_miss");
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "redir_pend");
        idle("redir_done");
        // redirect beats load-use; redirect under dwait waits for dhit
        step(1, 1, 1, 0, 1, 5'd3, 5'd3, 5'd3, 1, 0, "redir_lu");
        step(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, "redir_dw");
        step(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, "redir_dhit");

        // reset in the middle of a dcache wait
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "pre_rst_dw");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "rst_dw");
        idle("post_rst");

        // halt: freezes for 20 cycles regardless of inputs
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "halt");
        for (int i = 0; i < 20; i++)
            step(1, 1, 1, 0, 1, 5'd1, 5'd1, 5'd1, i[0], 0, "halted");
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_halt");

        // randomized traffic with occasional halts and resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 50),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 999) < 5),
                 "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
